iob_asym_fifo_sync: RTL and testbench
=====================================

IOB_ASYM_FIFO_SYNC -- requirements
Module: iob_asym_fifo_sync

Interface
REQ-001 The module SHALL have parameter W_DATA_W, default 8, meaning write port data width in bits.
REQ-002 The module SHALL have parameter R_DATA_W, default 32, meaning read port data width in bits.
REQ-003 The module SHALL have parameter ADDR_W, default 4, meaning log2 of storage depth counted in minDATA_W-wide entries; depth = 2**ADDR_W.
REQ-004 The module SHALL have port clk, input, 1, meaning the single clock; one clock, all logic on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-006 The module SHALL have port w_en, input, 1, meaning write request.
REQ-007 The module SHALL have port w_data, input, W_DATA_W, meaning write data.
REQ-008 The module SHALL have port w_full, output, 1, meaning fewer than W_RATIO free entries.
REQ-009 The module SHALL have port r_en, input, 1, meaning read request.
REQ-010 The module SHALL have port r_data, output, R_DATA_W, meaning registered read data.
REQ-011 The module SHALL have port r_empty, output, 1, meaning fewer than R_RATIO stored entries.
REQ-012 The module SHALL have port level, output, ADDR_W+1, meaning stored entries in minDATA_W units, range 0..2**ADDR_W.

Function
REQ-013 The module SHALL derive minDATA_W = min(W_DATA_W,R_DATA_W), W_RATIO = W_DATA_W/minDATA_W and R_RATIO = R_DATA_W/minDATA_W; either port may be the wider one, and equal widths (both ratios 1) SHALL be supported.
REQ-014 The module SHALL support only widths that are integer multiples of each other with power-of-two ratios and 2**ADDR_W >= max(W_RATIO,R_RATIO); other parameter sets are unsupported.
REQ-015 A write SHALL be accepted when w_en=1 and w_full=0; it stores w_data as W_RATIO consecutive entries, least-significant slice first, at wptr..wptr+W_RATIO-1.
REQ-016 A read SHALL be accepted when r_en=1 and r_empty=0; it concatenates R_RATIO consecutive entries from rptr, with the first entry in the least-significant slice of r_data.
REQ-017 Write pointer and read pointer SHALL advance by W_RATIO and R_RATIO per accepted operation and wrap modulo 2**ADDR_W.
REQ-018 r_data SHALL update on the clock edge that accepts a read (1-cycle latency) and hold its value otherwise, including for rejected reads.
REQ-019 A write with w_full=1, or a read with r_empty=1, SHALL be ignored, changing no pointer, level, storage or r_data.
REQ-020 w_full and r_empty SHALL be registered/derived from the current level: w_full = (2**ADDR_W - level) < W_RATIO, r_empty = level < R_RATIO.
REQ-021 On simultaneous read and write, acceptance of each SHALL be judged against the pre-edge flags; level_next = level + W_RATIO*wacc - R_RATIO*racc.
REQ-022 A write that is rejected because w_full=1 SHALL stay rejected even if a read is accepted in the same cycle (no same-cycle bypass).
REQ-023 A read of data written in the same cycle SHALL NOT occur; newly written data SHALL become readable no earlier than the following cycle.

Reset
REQ-024 While rst=1 at a clock edge, the module SHALL set wptr=0, rptr=0, level=0, r_data=0, r_empty=1 and w_full=0 (or w_full=1 if W_RATIO > 2**ADDR_W, which is unsupported), and ignore w_en and r_en.
REQ-025 Reset SHALL NOT be required to clear storage contents, and reset asserted mid-operation SHALL discard all stored data.

Verification
REQ-026 With defaults (W=8,R=32,ADDR_W=4): write 0x11,0x22,0x33 -> level=3, r_empty=1; write 0x44 -> r_empty=0; read -> next cycle r_data=0x44332211, level=0, r_empty=1.
REQ-027 With defaults, 16 byte writes -> level=16, w_full=1; a 17th write of 0xFF is ignored (level stays 16); 4 reads return the 16 bytes in order.
REQ-028 With W=32,R=8,ADDR_W=3: write 0xA1B2C3D4 -> level=4; 4 reads -> r_data D4,C3,B2,A1; a 5th read is ignored with r_data held at 0xA1.
REQ-029 With W=32,R=8,ADDR_W=3: fill to level=8, then assert read and write together -> read accepted, write rejected, level=7; then write 4 words while reading continuously -> data stays correct across pointer wrap.
REQ-030 With defaults at level=8, assert rst for 1 cycle with w_en=r_en=1 -> level=0, r_empty=1, w_full=0, r_data=0; the next read is ignored.

Source files
------------

// File: rtl/iob_asym_fifo_sync.sv
// Single-clock FIFO with independent write and read port widths.
// Storage is kept in min-width entries; each port moves a power-of-two number of entries per access.
module iob_asym_fifo_sync #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic [ADDR_W:0]     level
);

  localparam int MIN_W   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
  localparam int W_RATIO = W_DATA_W / MIN_W;
  localparam int R_RATIO = R_DATA_W / MIN_W;
  localparam int DEPTH   = 2 ** ADDR_W;

  localparam logic [ADDR_W:0]   W_INC    = (ADDR_W+1)'(W_RATIO);
  localparam logic [ADDR_W:0]   R_INC    = (ADDR_W+1)'(R_RATIO);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] W_STEP   = ADDR_W'(W_RATIO);
  localparam logic [ADDR_W-1:0] R_STEP   = ADDR_W'(R_RATIO);
  localparam logic              FULL_RST = (W_RATIO > DEPTH) ? 1'b1 : 1'b0;

  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                w_full_q, w_full_d;
  logic                r_empty_q, r_empty_d;
  logic [R_DATA_W-1:0] r_data_q, r_data_d;
  logic                wacc_s, racc_s;
  logic [MIN_W-1:0]    mem_s [DEPTH];

  // Acceptance is judged only against the flags registered before this edge.
  assign wacc_s = w_en & ~w_full_q & ~rst;
  assign racc_s = r_en & ~r_empty_q & ~rst;

  // Each entry captures its slice when it lies in the window wptr..wptr+W_RATIO-1.
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic [ADDR_W-1:0] off_s;
    logic              hit_s;
    logic [MIN_W-1:0]  slice_s;
    logic [MIN_W-1:0]  ent_q;

    assign off_s   = ADDR_W'(e) - wptr_q;
    assign hit_s   = ({1'b0, off_s} < W_INC);
    assign slice_s = MIN_W'(w_data >> (MIN_W * int'(off_s)));
    assign mem_s[e] = ent_q;

    always_ff @(posedge clk) begin
      if (wacc_s && hit_s) begin
        ent_q <= slice_s;
      end else begin
        ent_q <= ent_q;
      end
    end
  end

  always_comb begin
    wptr_d    = wacc_s ? (wptr_q + W_STEP) : wptr_q;
    rptr_d    = racc_s ? (rptr_q + R_STEP) : rptr_q;
    level_d   = level_q + (wacc_s ? W_INC : {(ADDR_W+1){1'b0}})
                        - (racc_s ? R_INC : {(ADDR_W+1){1'b0}});
    w_full_d  = ((DEPTH_L - level_d) < W_INC);
    r_empty_d = (level_d < R_INC);
    r_data_d  = r_data_q;
    if (racc_s) begin
      // First entry read lands in the least-significant slice.
      for (int i = 0; i < R_RATIO; i++) begin
        r_data_d[i*MIN_W +: MIN_W] = mem_s[rptr_q + ADDR_W'(i)];
      end
    end else begin
      r_data_d = r_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= {ADDR_W{1'b0}};
      rptr_q    <= {ADDR_W{1'b0}};
      level_q   <= {(ADDR_W+1){1'b0}};
      w_full_q  <= FULL_RST;
      r_empty_q <= 1'b1;
      r_data_q  <= {R_DATA_W{1'b0}};
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      w_full_q  <= w_full_d;
      r_empty_q <= r_empty_d;
      r_data_q  <= r_data_d;
    end
  end

  assign w_full  = w_full_q;
  assign r_empty = r_empty_q;
  assign r_data  = r_data_q;
  assign level   = level_q;

endmodule

// File: tb/tb_iob_asym_fifo_sync.sv
// Directed bench: a narrow-write/wide-read instance and a wide-write/narrow-read instance.
module tb_iob_asym_fifo_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (W=8, R=32, ADDR_W=4)
  logic        a_rst, a_w_en, a_r_en, a_w_full, a_r_empty;
  logic [7:0]  a_w_data;
  logic [31:0] a_r_data;
  logic [4:0]  a_level;

  // Instance B: W=32, R=8, ADDR_W=3
  logic        b_rst, b_w_en, b_r_en, b_w_full, b_r_empty;
  logic [31:0] b_w_data;
  logic [7:0]  b_r_data;
  logic [3:0]  b_level;

  iob_asym_fifo_sync u_a (
    .clk(clk), .rst(a_rst), .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full),
    .r_en(a_r_en), .r_data(a_r_data), .r_empty(a_r_empty), .level(a_level)
  );

  iob_asym_fifo_sync #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(3)) u_b (
    .clk(clk), .rst(b_rst), .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full),
    .r_en(b_r_en), .r_data(b_r_data), .r_empty(b_r_empty), .level(b_level)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state for instance B
  int         mlvl = 0;
  logic [7:0] bq[$];
  logic [7:0] last_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_wr(input logic [7:0] d);
    a_w_en = 1'b1; a_w_data = d;
    tick();
    a_w_en = 1'b0;
  endtask

  task automatic a_rd();
    a_r_en = 1'b1;
    tick();
    a_r_en = 1'b0;
  endtask

  task automatic b_rd();
    b_r_en = 1'b1;
    tick();
    b_r_en = 1'b0;
  endtask

  task automatic step_b(input logic we, input logic [31:0] wd, input logic re, output logic wacc);
    logic racc;
    wacc = we && ((8 - mlvl) >= 4);
    racc = re && (mlvl >= 1);
    b_w_en = we; b_w_data = wd; b_r_en = re;
    tick();
    b_w_en = 1'b0; b_r_en = 1'b0;
    if (racc) last_r = bq.pop_front();
    if (wacc) for (int i = 0; i < 4; i++) bq.push_back(wd[i*8 +: 8]);
    mlvl = mlvl + (wacc ? 4 : 0) - (racc ? 1 : 0);
    check("b_rdata", 32'(b_r_data), 32'(last_r));
    check("b_level", 32'(b_level), 32'(mlvl));
    check("b_full",  32'(b_w_full), 32'((8 - mlvl) < 4));
    check("b_empty", 32'(b_r_empty), 32'(mlvl < 1));
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [31:0] words [4];
    logic        acc;
    int          idx;
    int          cyc;

    a_rst = 1'b1; a_w_en = 1'b0; a_r_en = 1'b0; a_w_data = 8'h00;
    b_rst = 1'b1; b_w_en = 1'b0; b_r_en = 1'b0; b_w_data = 32'h0;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;

    check("a_rst_level", 32'(a_level), 32'd0);
    check("a_rst_empty", 32'(a_r_empty), 32'd1);
    check("a_rst_full",  32'(a_w_full), 32'd0);
    check("a_rst_rdata", a_r_data, 32'd0);

    // Narrow writes assemble one wide word
    a_wr(8'h11); a_wr(8'h22); a_wr(8'h33);
    check("a_lvl3", 32'(a_level), 32'd3);
    check("a_empty3", 32'(a_r_empty), 32'd1);
    a_wr(8'h44);
    check("a_empty4", 32'(a_r_empty), 32'd0);
    check("a_lvl4", 32'(a_level), 32'd4);
    a_rd();
    check("a_word", a_r_data, 32'h4433_2211);
    check("a_lvl0", 32'(a_level), 32'd0);
    check("a_empty0", 32'(a_r_empty), 32'd1);

    // Fill to full across the wrap, overflow write ignored
    for (int k = 0; k < 16; k++) a_wr(8'(8'hA0 + k));
    check("a_lvl16", 32'(a_level), 32'd16);
    check("a_full16", 32'(a_w_full), 32'd1);
    a_wr(8'hFF);
    check("a_ovf_lvl", 32'(a_level), 32'd16);
    for (int j = 0; j < 4; j++) begin
      a_rd();
      for (int i = 0; i < 4; i++) exp_w[i*8 +: 8] = 8'(8'hA0 + 4*j + i);
      check("a_drain", a_r_data, exp_w);
    end
    check("a_drain_lvl", 32'(a_level), 32'd0);
    check("a_drain_full", 32'(a_w_full), 32'd0);

    // Reset mid-operation with both requests asserted
    for (int k = 0; k < 8; k++) a_wr(8'(k + 1));
    check("a_lvl8", 32'(a_level), 32'd8);
    a_rst = 1'b1; a_w_en = 1'b1; a_r_en = 1'b1;
    tick();
    a_rst = 1'b0; a_w_en = 1'b0;
    check("a_mrst_lvl", 32'(a_level), 32'd0);
    check("a_mrst_empty", 32'(a_r_empty), 32'd1);
    check("a_mrst_full", 32'(a_w_full), 32'd0);
    check("a_mrst_rdata", a_r_data, 32'd0);
    tick();
    a_r_en = 1'b0;
    check("a_post_rd_data", a_r_data, 32'd0);
    check("a_post_rd_lvl", 32'(a_level), 32'd0);

    // Instance B: wide write, narrow reads
    check("b_rst_lvl", 32'(b_level), 32'd0);
    check("b_rst_empty", 32'(b_r_empty), 32'd1);
    b_w_en = 1'b1; b_w_data = 32'hA1B2_C3D4;
    tick();
    b_w_en = 1'b0;
    check("b_lvl4", 32'(b_level), 32'd4);
    check("b_full4", 32'(b_w_full), 32'd0);
    b_rd(); check("b_rd0", 32'(b_r_data), 32'hD4);
    b_rd(); check("b_rd1", 32'(b_r_data), 32'hC3);
    b_rd(); check("b_rd2", 32'(b_r_data), 32'hB2);
    b_rd(); check("b_rd3", 32'(b_r_data), 32'hA1);
    b_rd();
    check("b_rd_hold", 32'(b_r_data), 32'hA1);
    check("b_rd_hold_lvl", 32'(b_level), 32'd0);

    // Fill, then simultaneous read/write against a full FIFO
    last_r = 8'hA1;
    step_b(1'b1, 32'h0403_0201, 1'b0, acc);
    step_b(1'b1, 32'h0807_0605, 1'b0, acc);
    check("b_fill_lvl", 32'(b_level), 32'd8);
    check("b_fill_full", 32'(b_w_full), 32'd1);
    step_b(1'b1, 32'h0C0B_0A09, 1'b1, acc);
    check("b_simul_rdata", 32'(b_r_data), 32'h01);
    check("b_simul_lvl", 32'(b_level), 32'd7);

    // Stream four words in while reading every cycle
    words[0] = 32'h0C0B_0A09; words[1] = 32'h100F_0E0D;
    words[2] = 32'h1413_1211; words[3] = 32'h1817_1615;
    idx = 0; cyc = 0;
    while ((idx < 4 || bq.size() > 0) && cyc < 200) begin
      step_b(idx < 4, words[idx < 4 ? idx : 3], 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    check("b_stream_done", 32'(idx), 32'd4);
    check("b_stream_lvl", 32'(b_level), 32'd0);
    check("b_stream_last", 32'(b_r_data), 32'h18);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
